param_fifo: RTL and testbench
=============================

PARAM_FIFO -- requirements
Module: param_fifo

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, giving the word width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 16, giving the entry count; it is a power of two and at least 2.
REQ-003 The block SHALL have parameter AF_LEVEL, default DEPTH-2, giving the almost_full threshold.
REQ-004 The block SHALL have parameter AE_LEVEL, default 2, giving the almost_empty threshold.
REQ-005 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port rstn, input, 1 bit, an asynchronous active-low reset.
REQ-007 The block SHALL have port flush, input, 1 bit, a synchronous clear of FIFO contents and error flags.
REQ-008 The block SHALL have port wr_en, input, 1 bit, a write request.
REQ-009 The block SHALL have port data_in, input, DATA_WIDTH bits, the write data.
REQ-010 The block SHALL have port rd_en, input, 1 bit, a read request.
REQ-011 The block SHALL have port data_out, output (registered), DATA_WIDTH bits, the read data.
REQ-012 The block SHALL have port rd_valid, output (registered), 1 bit, high for one cycle when data_out was updated by a read.
REQ-013 The block SHALL have port count, output, $clog2(DEPTH)+1 bits, the number of stored entries (0..DEPTH).
REQ-014 The block SHALL have outputs full, empty, almost_full and almost_empty, each 1 bit, the status flags.
REQ-015 The block SHALL have outputs overflow and underflow, each 1 bit, sticky error flags.

Function
REQ-016 A write SHALL be accepted iff wr_en=1, full=0 and flush=0; it stores data_in at wr_ptr, and wr_ptr increments modulo DEPTH.
REQ-017 A read SHALL be accepted iff rd_en=1, empty=0 and flush=0; on the next edge data_out<=mem[rd_ptr], rd_valid<=1, and rd_ptr increments modulo DEPTH.
REQ-018 rd_valid SHALL be 0 in every cycle following a non-accepted read, and data_out SHALL hold its value.
REQ-019 For an accepted write only, count SHALL increment by 1; for an accepted read only, count SHALL decrement by 1; for both in one cycle, count SHALL be unchanged.
REQ-020 With full=1 and wr_en=rd_en=1, only the read SHALL be accepted; count becomes DEPTH-1.
REQ-021 With empty=1 and wr_en=rd_en=1, only the write SHALL be accepted; there is no fall-through, count becomes 1, and rd_valid=0.
REQ-022 The flags SHALL be combinational from count: full=(count==DEPTH), empty=(count==0), almost_full=(count>=AF_LEVEL), almost_empty=(count<=AE_LEVEL).
REQ-023 All DEPTH entries SHALL be usable; no slot is reserved to distinguish full from empty.
REQ-024 overflow SHALL be set on an edge where wr_en=1 and full=1, and underflow on an edge where rd_en=1 and empty=1; both hold until flush or reset.
REQ-025 When flush=1, it SHALL take priority over wr_en and rd_en: pointers 0, count 0, overflow/underflow 0, rd_valid 0, data_out held, memory contents untouched.
REQ-026 Simultaneous flush with full/empty error conditions SHALL NOT set overflow or underflow.
REQ-027 Pointer wrap SHALL be seamless: data order is preserved across any number of wraps.

Reset
REQ-028 While rstn=0, regardless of clk, the block SHALL force data_out=0, rd_valid=0, count=0, empty=1, almost_empty=1, full=0, almost_full=0, overflow=0, underflow=0, and both pointers to 0.
REQ-029 Memory contents SHALL NOT be reset.
REQ-030 Reset asserted mid-operation SHALL abort any in-flight read or write, which have no effect after reset release.
REQ-031 The first edge after rstn deasserts SHALL operate normally.

Verification (DATA_WIDTH=8, DEPTH=4, AF_LEVEL=3, AE_LEVEL=1)
REQ-032 Fill/drain: write 0x11,0x22,0x33,0x44 -> count=4, full=1, almost_full=1 after the 3rd write; then four reads -> data_out 0x11,0x22,0x33,0x44 with rd_valid high each cycle; empty=1 at the end.
REQ-033 Overflow/underflow: at full, write 0x55 -> rejected, overflow=1, count=4; drain, then read at empty -> underflow=1, rd_valid=0, data_out=0x44 held.
REQ-034 Simultaneous: at count=2, wr_en=rd_en=1 for 3 cycles -> count stays 2, order preserved across the pointer wrap; at empty with both asserted -> count=1, rd_valid=0.
REQ-035 Flush: at count=3 with overflow=1, flush=1 together with wr_en=1 -> count=0, empty=1, overflow=0, data_out unchanged.
REQ-036 Async reset: assert rstn=0 between clock edges with count=3 -> all outputs take their reset values immediately; after release, write 0xA5 then read -> data_out=0xA5.

Source files
------------

// File: rtl/param_fifo_if.sv
// Handshake and status bundle for param_fifo. The bench drives the master side
// and the FIFO sits on the slave side.
interface param_fifo_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic                  flush;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  rd_valid;
    logic [CW-1:0]         count;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output flush, wr_en, data_in, rd_en,
        input  data_out, rd_valid, count, full, empty,
               almost_full, almost_empty, overflow, underflow
    );

    modport slave (
        input  flush, wr_en, data_in, rd_en,
        output data_out, rd_valid, count, full, empty,
               almost_full, almost_empty, overflow, underflow
    );
endinterface

// File: rtl/param_fifo.sv
// Synchronous FIFO with a registered read port, an occupancy counter, threshold
// flags derived from that counter, and sticky overflow/underflow errors.
// The counter uses one more bit than the pointers, so every slot can be used.
module param_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AF_LEVEL   = DEPTH - 2,
    parameter int AE_LEVEL   = 2
) (
    input  logic           clk,
    input  logic           rstn,
    param_fifo_if.slave    bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic [DATA_WIDTH-1:0] r_data_out;
    logic                  r_rd_valid;
    logic                  r_overflow;
    logic                  r_underflow;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic [CW-1:0]         w_count_nxt;

    assign w_full   = (r_count == CW'(DEPTH));
    assign w_empty  = (r_count == CW'(0));
    // Flush overrides both requests, so neither side is accepted while it is high.
    assign w_wr_acc = bus.wr_en & ~w_full  & ~bus.flush;
    assign w_rd_acc = bus.rd_en & ~w_empty & ~bus.flush;

    // Next occupancy: a simultaneous write and read leaves the count unchanged.
    always_comb begin
        w_count_nxt = r_count;
        case ({w_wr_acc, w_rd_acc})
            2'b10:   w_count_nxt = r_count + CW'(1);
            2'b01:   w_count_nxt = r_count - CW'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // Storage array; left unreset. A write during reset is harmless because
    // the pointers and the count are held at zero.
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr] <= bus.data_in;
        end
    end

    // Control state: pointers, count, read port and sticky error flags.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr    <= AW'(0);
            r_rd_ptr    <= AW'(0);
            r_count     <= CW'(0);
            r_data_out  <= DATA_WIDTH'(0);
            r_rd_valid  <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (bus.flush) begin
            r_wr_ptr    <= AW'(0);
            r_rd_ptr    <= AW'(0);
            r_count     <= CW'(0);
            r_rd_valid  <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_rd_acc) begin
                r_data_out <= r_mem[r_rd_ptr];
                r_rd_ptr   <= r_rd_ptr + AW'(1);
            end
            r_rd_valid <= w_rd_acc;
            r_count    <= w_count_nxt;
            if (bus.wr_en && w_full) begin
                r_overflow <= 1'b1;
            end
            if (bus.rd_en && w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign bus.data_out     = r_data_out;
    assign bus.rd_valid     = r_rd_valid;
    assign bus.count        = r_count;
    assign bus.full         = w_full;
    assign bus.empty        = w_empty;
    assign bus.almost_full  = (r_count >= CW'(AF_LEVEL));
    assign bus.almost_empty = (r_count <= CW'(AE_LEVEL));
    assign bus.overflow     = r_overflow;
    assign bus.underflow    = r_underflow;
endmodule

// File: tb/tb_param_fifo.sv
// Self-checking bench for param_fifo (DEPTH=4). A directed vector table covers
// fill/drain, errors, simultaneous access and flush. Hand sequences cover the
// asynchronous reset. A randomized phase is then checked against a queue model.
module tb_param_fifo;
    localparam int DW  = 8;
    localparam int DP  = 4;
    localparam int AFL = 3;
    localparam int AEL = 1;

    logic clk;
    logic rstn;

    param_fifo_if #(.DATA_WIDTH(DW), .DEPTH(DP)) bus ();

    param_fifo #(
        .DATA_WIDTH(DW), .DEPTH(DP), .AF_LEVEL(AFL), .AE_LEVEL(AEL)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: a queue plus the registered read port and sticky flags.
    logic [DW-1:0] m_q[$];
    logic [DW-1:0] m_dout;
    logic          m_rv;
    logic          m_ovf;
    logic          m_udf;

    typedef struct packed {
        logic          wr;
        logic [DW-1:0] din;
        logic          rd;
        logic          fl;
        logic [DW-1:0] e_dout;
        logic          e_rv;
        logic [2:0]    e_count;
        logic          e_full;
        logic          e_empty;
        logic          e_ovf;
        logic          e_udf;
    } vec_t;

    vec_t vecs[21];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_dout = 8'h00;
        m_rv   = 1'b0;
        m_ovf  = 1'b0;
        m_udf  = 1'b0;
    endtask

    task automatic model_step(input logic wr, input logic [DW-1:0] din, input logic rd, input logic fl);
        bit was_full;
        bit was_empty;
        if (fl) begin
            m_q.delete();
            m_rv  = 1'b0;
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            was_full  = (m_q.size() == DP);
            was_empty = (m_q.size() == 0);
            if (wr && was_full)  m_ovf = 1'b1;
            if (rd && was_empty) m_udf = 1'b1;
            m_rv = rd && !was_empty;
            if (m_rv) m_dout = m_q.pop_front();
            if (wr && !was_full) m_q.push_back(din);
        end
    endtask

    task automatic check_model(input string tag);
        int c;
        c = m_q.size();
        chk({tag, ".data_out"},     32'(bus.data_out),     32'(m_dout));
        chk({tag, ".rd_valid"},     32'(bus.rd_valid),     32'(m_rv));
        chk({tag, ".count"},        32'(bus.count),        32'(c));
        chk({tag, ".full"},         32'(bus.full),         32'(c == DP));
        chk({tag, ".empty"},        32'(bus.empty),        32'(c == 0));
        chk({tag, ".almost_full"},  32'(bus.almost_full),  32'(c >= AFL));
        chk({tag, ".almost_empty"}, 32'(bus.almost_empty), 32'(c <= AEL));
        chk({tag, ".overflow"},     32'(bus.overflow),     32'(m_ovf));
        chk({tag, ".underflow"},    32'(bus.underflow),    32'(m_udf));
    endtask

    // Apply one cycle of inputs, advance the model, sample 1 ns after the edge.
    task automatic cycle(input logic wr, input logic [DW-1:0] din, input logic rd, input logic fl);
        bus.wr_en   = wr;
        bus.data_in = din;
        bus.rd_en   = rd;
        bus.flush   = fl;
        model_step(wr, din, rd, fl);
        @(posedge clk);
        #1;
    endtask

    initial begin
        //             wr    din    rd    fl   dout   rv   cnt  full  emp  ovf  udf
        vecs[0]  = '{1'b1, 8'h11, 1'b0, 1'b0, 8'h00, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 8'h22, 1'b0, 1'b0, 8'h00, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 8'h33, 1'b0, 1'b0, 8'h00, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 8'h44, 1'b0, 1'b0, 8'h00, 1'b0, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 8'h55, 1'b0, 1'b0, 8'h00, 1'b0, 3'd4, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h11, 1'b1, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h22, 1'b1, 3'd2, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h33, 1'b1, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h44, 1'b1, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h44, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[10] = '{1'b1, 8'h66, 1'b0, 1'b0, 8'h44, 1'b0, 3'd1, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[11] = '{1'b1, 8'h77, 1'b0, 1'b0, 8'h44, 1'b0, 3'd2, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[12] = '{1'b1, 8'h88, 1'b1, 1'b0, 8'h66, 1'b1, 3'd2, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[13] = '{1'b1, 8'h99, 1'b1, 1'b0, 8'h77, 1'b1, 3'd2, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[14] = '{1'b1, 8'hAA, 1'b1, 1'b0, 8'h88, 1'b1, 3'd2, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[15] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h99, 1'b1, 3'd1, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[16] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'hAA, 1'b1, 3'd0, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[17] = '{1'b1, 8'hBB, 1'b1, 1'b0, 8'hAA, 1'b0, 3'd1, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[18] = '{1'b1, 8'hCC, 1'b0, 1'b0, 8'hAA, 1'b0, 3'd2, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[19] = '{1'b1, 8'hDD, 1'b0, 1'b0, 8'hAA, 1'b0, 3'd3, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[20] = '{1'b1, 8'hEE, 1'b0, 1'b1, 8'hAA, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0};

        // Hold the FIFO in reset, then check the reset values.
        rstn        = 1'b0;
        bus.wr_en   = 1'b0;
        bus.rd_en   = 1'b0;
        bus.flush   = 1'b0;
        bus.data_in = 8'h00;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_model("reset");
        chk("reset.data_out_zero", 32'(bus.data_out), 32'h0);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // Directed vector table.
        for (int i = 0; i < 21; i++) begin
            cycle(vecs[i].wr, vecs[i].din, vecs[i].rd, vecs[i].fl);
            chk($sformatf("vec%0d.data_out", i), 32'(bus.data_out),  32'(vecs[i].e_dout));
            chk($sformatf("vec%0d.rd_valid", i), 32'(bus.rd_valid),  32'(vecs[i].e_rv));
            chk($sformatf("vec%0d.count", i),    32'(bus.count),     32'(vecs[i].e_count));
            chk($sformatf("vec%0d.full", i),     32'(bus.full),      32'(vecs[i].e_full));
            chk($sformatf("vec%0d.empty", i),    32'(bus.empty),     32'(vecs[i].e_empty));
            chk($sformatf("vec%0d.overflow", i), 32'(bus.overflow),  32'(vecs[i].e_ovf));
            chk($sformatf("vec%0d.underflow", i),32'(bus.underflow), 32'(vecs[i].e_udf));
            check_model($sformatf("vec%0d", i));
        end

        // Asynchronous reset between edges with three entries stored.
        cycle(1'b1, 8'h01, 1'b0, 1'b0);
        cycle(1'b1, 8'h02, 1'b1, 1'b0);
        cycle(1'b1, 8'h03, 1'b0, 1'b0);
        cycle(1'b1, 8'h04, 1'b0, 1'b0);
        chk("pre_reset.count", 32'(bus.count), 32'd3);
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        #2;
        rstn = 1'b0;
        #1;
        model_reset();
        check_model("async_reset");
        chk("async_reset.data_out_zero", 32'(bus.data_out), 32'h0);

        // A write and a read held during reset must leave no trace.
        bus.wr_en   = 1'b1;
        bus.rd_en   = 1'b1;
        bus.data_in = 8'h5A;
        @(posedge clk);
        #1;
        check_model("in_reset");
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        #2;
        rstn = 1'b1;
        cycle(1'b1, 8'hA5, 1'b0, 1'b0);
        check_model("post_reset_wr");
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        check_model("post_reset_rd");
        chk("post_reset.data_out", 32'(bus.data_out), 32'hA5);
        chk("post_reset.rd_valid", 32'(bus.rd_valid), 32'h1);

        // Randomized traffic against the queue model.
        for (int i = 0; i < 400; i++) begin
            logic          r_wr;
            logic          r_rd;
            logic          r_fl;
            logic [DW-1:0] r_din;
            r_wr  = 1'($urandom_range(0, 1));
            r_rd  = 1'($urandom_range(0, 1));
            r_fl  = ($urandom_range(0, 31) == 0);
            r_din = 8'($urandom);
            cycle(r_wr, r_din, r_rd, r_fl);
            check_model($sformatf("rand%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
